// File: rtl/axi4_read_responder.sv
// AXI4 read-channel subordinate in front of a single-port word-addressed RAM.
// Accepts one AR burst at a time, sequences FIXED/INCR/WRAP beat addresses,
// fetches each beat from the RAM and returns it on R with RID/RRESP/RLAST.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   s_ar*                 AR channel (s_arready registered)
//   s_r*                  R channel, honours s_rready backpressure
//   mem_req/mem_addr      RAM read strobe and word address
//   mem_rdata             RAM data, valid the cycle after mem_req, held
module axi4_read_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_WORDS  = 1024,
    parameter int MEM_AW     = $clog2(MEM_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   s_arid,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic [7:0]            s_arlen,
    input  logic [2:0]            s_arsize,
    input  logic [1:0]            s_arburst,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [ID_WIDTH-1:0]   s_rid,
    output logic [DATA_WIDTH-1:0] s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rlast,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic                  mem_req,
    output logic [MEM_AW-1:0]     mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int OFF       = $clog2(BYTES);
    localparam int MEM_BYTES = MEM_WORDS * BYTES;
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(MEM_BYTES);

    localparam logic [1:0] B_FIXED = 2'b00;
    localparam logic [1:0] B_WRAP  = 2'b10;
    localparam logic [1:0] B_RSVD  = 2'b11;

    localparam logic [1:0] R_OKAY   = 2'b00;
    localparam logic [1:0] R_SLVERR = 2'b10;
    localparam logic [1:0] R_DECERR = 2'b11;

    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

    state_t                state_q, state_d;
    logic                  arready_q, arready_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    logic [7:0]            beat_q, beat_d;
    logic [1:0]            resp_q, resp_d;

    logic [ADDR_WIDTH-1:0] bytes, total, lower, incr, nxt;
    logic ar_hs, wrap_ok, illegal, decerr, last;

    // Next beat address; WRAP window is derived from the current address,
    // which always stays inside the same window as the start address.
    always_comb begin
        bytes = ADDR_WIDTH'(1) << size_q;
        total = bytes * (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1));
        lower = addr_q & ~(total - ADDR_WIDTH'(1));
        incr  = addr_q + bytes;
        unique case (burst_q)
            B_FIXED: nxt = addr_q;
            B_WRAP:  nxt = (incr == lower + total) ? lower : incr;
            default: nxt = (addr_q & ~(bytes - ADDR_WIDTH'(1))) + bytes;
        endcase
    end

    always_comb begin
        ar_hs   = (state_q == IDLE) && arready_q && s_arvalid;
        wrap_ok = (s_arlen == 8'd1) || (s_arlen == 8'd3) ||
                  (s_arlen == 8'd7) || (s_arlen == 8'd15);
        illegal = (s_arsize > 3'(OFF)) || (s_arburst == B_RSVD) ||
                  ((s_arburst == B_WRAP) && !wrap_ok);
        decerr  = {1'b0, addr_q} >= LIMIT;
        last    = (beat_q == len_q);
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        beat_d  = beat_q;
        resp_d  = resp_q;
        unique case (state_q)
            IDLE: begin
                if (ar_hs) begin
                    id_d    = s_arid;
                    addr_d  = s_araddr;
                    len_d   = s_arlen;
                    size_d  = s_arsize;
                    burst_d = s_arburst;
                    beat_d  = 8'd0;
                    resp_d  = illegal ? R_SLVERR : R_OKAY;
                    state_d = illegal ? DATA : FETCH;
                end
            end
            FETCH: begin
                resp_d  = decerr ? R_DECERR : R_OKAY;
                state_d = DATA;
            end
            DATA: begin
                if (s_rready) begin
                    if (last) begin
                        state_d = IDLE;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                        addr_d  = nxt;
                        // SLVERR bursts skip the RAM entirely
                        state_d = (resp_q == R_SLVERR) ? DATA : FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        arready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            arready_q <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            beat_q    <= '0;
            resp_q    <= '0;
        end else begin
            state_q   <= state_d;
            arready_q <= arready_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            beat_q    <= beat_d;
            resp_q    <= resp_d;
        end
    end

    // R outputs are gated by state so they clear asynchronously on reset.
    always_comb begin
        s_arready = arready_q;
        s_rvalid  = (state_q == DATA);
        s_rid     = s_rvalid ? id_q : '0;
        s_rresp   = s_rvalid ? resp_q : R_OKAY;
        s_rlast   = s_rvalid && last;
        s_rdata   = (s_rvalid && resp_q == R_OKAY) ? mem_rdata : '0;
        mem_req   = (state_q == FETCH) && !decerr;
        mem_addr  = mem_req ? addr_q[OFF +: MEM_AW] : '0;
    end

endmodule

// File: tb/tb_axi4_read_responder.sv
// Directed self-checking bench for axi4_read_responder.
// RAM word w holds 32'hA500_0000 | w.
module tb_axi4_read_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  s_arid = '0;
    logic [31:0] s_araddr = '0;
    logic [7:0]  s_arlen = '0;
    logic [2:0]  s_arsize = '0;
    logic [1:0]  s_arburst = '0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [3:0]  s_rid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic        s_rvalid;
    logic        s_rready = 1'b1;
    logic        mem_req;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata = '0;

    logic [31:0] ram [1024];
    int pass_cnt = 0;
    int total_cnt = 0;

    axi4_read_responder dut (
        .clk(clk), .rst_n(rst_n),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_req) mem_rdata <= ram[mem_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired, got timeout, required finish");
        $fatal(1);
    end

    // Drives one AR request; caller guarantees s_arready at the next edge.
    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst);
        s_arid = id; s_araddr = addr; s_arlen = len;
        s_arsize = size; s_arburst = burst; s_arvalid = 1'b1;
        @(posedge clk); #1;
        s_arvalid = 1'b0;
    endtask

    task automatic test_reset();
        logic [52:0] got;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        got = {s_arready, s_rvalid, s_rlast, s_rid, s_rresp, s_rdata,
               mem_req, mem_addr};
        total_cnt++;
        if (got !== 53'd0) $display("FAIL reset_outs: got %h required 0", got);
        else pass_cnt++;
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (s_arready !== 1'b0) $display("FAIL arready_pre_edge: got %b required 0", s_arready);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (s_arready !== 1'b1) $display("FAIL arready_post_rst: got %b required 1", s_arready);
        else pass_cnt++;
    endtask

    task automatic test_incr();
        logic [9:0]  ea [4] = '{10'h4, 10'h5, 10'h6, 10'h7};
        logic [39:0] got, exp;
        s_rready = 1'b1;
        do_ar(4'h5, 32'h10, 8'd3, 3'd2, 2'b01);
        total_cnt++;
        if (s_arready !== 1'b0) $display("FAIL incr_arready_c1: got %b required 0", s_arready);
        else pass_cnt++;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            total_cnt++;
            if ({s_rvalid, mem_req, mem_addr} !== {2'b01, ea[b]})
                $display("FAIL incr_fetch%0d: got rv=%b req=%b addr=%h required rv=0 req=1 addr=%h",
                         b, s_rvalid, mem_req, mem_addr, ea[b]);
            else pass_cnt++;
            @(negedge clk);
            got = {s_rvalid, s_rlast, s_rresp, s_rid, s_rdata};
            exp = {1'b1, b == 3, 2'b00, 4'h5, 32'hA500_0000 | 32'(ea[b])};
            total_cnt++;
            if (got !== exp) $display("FAIL incr_beat%0d: got %h required %h", b, got, exp);
            else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if ({s_arready, s_rvalid} !== 2'b10)
            $display("FAIL incr_done: got %b required 10", {s_arready, s_rvalid});
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [9:0]  ea [4] = '{10'hE, 10'hF, 10'hC, 10'hD};
        logic [39:0] got, exp;
        do_ar(4'hA, 32'h38, 8'd3, 3'd2, 2'b10);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            total_cnt++;
            if ({mem_req, mem_addr} !== {1'b1, ea[b]})
                $display("FAIL wrap_fetch%0d: got req=%b addr=%h required req=1 addr=%h",
                         b, mem_req, mem_addr, ea[b]);
            else pass_cnt++;
            @(negedge clk);
            got = {s_rvalid, s_rlast, s_rresp, s_rid, s_rdata};
            exp = {1'b1, b == 3, 2'b00, 4'hA, 32'hA500_0000 | 32'(ea[b])};
            total_cnt++;
            if (got !== exp) $display("FAIL wrap_beat%0d: got %h required %h", b, got, exp);
            else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if (s_arready !== 1'b1) $display("FAIL wrap_arready: got %b required 1", s_arready);
        else pass_cnt++;
    endtask

    task automatic test_fixed();
        logic [39:0] got, exp;
        do_ar(4'h3, 32'h20, 8'd2, 3'd2, 2'b00);
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            total_cnt++;
            if ({mem_req, mem_addr} !== {1'b1, 10'h8})
                $display("FAIL fixed_fetch%0d: got req=%b addr=%h required req=1 addr=008",
                         b, mem_req, mem_addr);
            else pass_cnt++;
            @(negedge clk);
            got = {s_rvalid, s_rlast, s_rresp, s_rid, s_rdata};
            exp = {1'b1, b == 2, 2'b00, 4'h3, 32'hA500_0008};
            total_cnt++;
            if (got !== exp) $display("FAIL fixed_beat%0d: got %h required %h", b, got, exp);
            else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if (s_arready !== 1'b1) $display("FAIL fixed_arready: got %b required 1", s_arready);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [40:0] got, exp;
        s_rready = 1'b0;
        do_ar(4'h6, 32'h40, 8'd1, 3'd2, 2'b01);
        @(negedge clk);
        total_cnt++;
        if ({mem_req, mem_addr} !== {1'b1, 10'h10})
            $display("FAIL bp_fetch0: got req=%b addr=%h required req=1 addr=010", mem_req, mem_addr);
        else pass_cnt++;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            got = {s_rvalid, s_rlast, s_rresp, s_rid, s_rdata, mem_req};
            exp = {1'b1, 1'b0, 2'b00, 4'h6, 32'hA500_0010, 1'b0};
            total_cnt++;
            if (got !== exp) $display("FAIL bp_hold%0d: got %h required %h", c, got, exp);
            else pass_cnt++;
        end
        s_rready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({s_rvalid, mem_req, mem_addr} !== {2'b01, 10'h11})
            $display("FAIL bp_fetch1: got rv=%b req=%b addr=%h required rv=0 req=1 addr=011",
                     s_rvalid, mem_req, mem_addr);
        else pass_cnt++;
        @(negedge clk);
        got = {s_rvalid, s_rlast, s_rresp, s_rid, s_rdata, mem_req};
        exp = {1'b1, 1'b1, 2'b00, 4'h6, 32'hA500_0011, 1'b0};
        total_cnt++;
        if (got !== exp) $display("FAIL bp_beat1: got %h required %h", got, exp);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_slverr();
        logic [40:0] got, exp;
        do_ar(4'h9, 32'h0, 8'd2, 3'd2, 2'b10);
        for (int b = 0; b < 3; b++) begin
            got = {s_rvalid, s_rlast, s_rresp, s_rid, s_rdata, mem_req};
            exp = {1'b1, b == 2, 2'b10, 4'h9, 32'h0, 1'b0};
            @(negedge clk);
            got = {s_rvalid, s_rlast, s_rresp, s_rid, s_rdata, mem_req};
            total_cnt++;
            if (got !== exp) $display("FAIL slverr_beat%0d: got %h required %h", b, got, exp);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        total_cnt++;
        if ({s_arready, s_rvalid, mem_req} !== 3'b100)
            $display("FAIL slverr_done: got %b required 100", {s_arready, s_rvalid, mem_req});
        else pass_cnt++;
        do_ar(4'h4, 32'h0, 8'd0, 3'd2, 2'b11);
        @(negedge clk);
        got = {s_rvalid, s_rlast, s_rresp, s_rid, s_rdata, mem_req};
        exp = {1'b1, 1'b1, 2'b10, 4'h4, 32'h0, 1'b0};
        total_cnt++;
        if (got !== exp) $display("FAIL rsvd_burst: got %h required %h", got, exp);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_decerr();
        logic [39:0] got, exp;
        do_ar(4'h2, 32'hFFC, 8'd1, 3'd2, 2'b01);
        @(negedge clk);
        total_cnt++;
        if ({mem_req, mem_addr} !== {1'b1, 10'h3FF})
            $display("FAIL dec_fetch0: got req=%b addr=%h required req=1 addr=3ff", mem_req, mem_addr);
        else pass_cnt++;
        @(negedge clk);
        got = {s_rvalid, s_rlast, s_rresp, s_rid, s_rdata};
        exp = {1'b1, 1'b0, 2'b00, 4'h2, 32'hA500_03FF};
        total_cnt++;
        if (got !== exp) $display("FAIL dec_beat0: got %h required %h", got, exp);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({s_rvalid, mem_req} !== 2'b00)
            $display("FAIL dec_fetch1: got rv=%b req=%b required 0 0", s_rvalid, mem_req);
        else pass_cnt++;
        @(negedge clk);
        got = {s_rvalid, s_rlast, s_rresp, s_rid, s_rdata};
        exp = {1'b1, 1'b1, 2'b11, 4'h2, 32'h0};
        total_cnt++;
        if (got !== exp) $display("FAIL dec_beat1: got %h required %h", got, exp);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [52:0] got;
        logic [39:0] g2, e2;
        do_ar(4'h1, 32'h0, 8'd7, 3'd2, 2'b01);
        repeat (6) @(negedge clk);
        total_cnt++;
        if (s_rvalid !== 1'b1) $display("FAIL mid_beat2_valid: got %b required 1", s_rvalid);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        got = {s_arready, s_rvalid, s_rlast, s_rid, s_rresp, s_rdata,
               mem_req, mem_addr};
        total_cnt++;
        if (got !== 53'd0) $display("FAIL mid_async_clear: got %h required 0", got);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({s_arready, s_rvalid} !== 2'b10)
            $display("FAIL mid_arready: got %b required 10", {s_arready, s_rvalid});
        else pass_cnt++;
        do_ar(4'hC, 32'h8, 8'd1, 3'd2, 2'b01);
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            total_cnt++;
            if ({mem_req, mem_addr} !== {1'b1, 10'(2 + b)})
                $display("FAIL mid_new_fetch%0d: got req=%b addr=%h required req=1 addr=%h",
                         b, mem_req, mem_addr, 10'(2 + b));
            else pass_cnt++;
            @(negedge clk);
            g2 = {s_rvalid, s_rlast, s_rresp, s_rid, s_rdata};
            e2 = {1'b1, b == 1, 2'b00, 4'hC, 32'hA500_0002 + 32'(b)};
            total_cnt++;
            if (g2 !== e2) $display("FAIL mid_new_beat%0d: got %h required %h", b, g2, e2);
            else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if (s_arready !== 1'b1) $display("FAIL mid_new_done: got %b required 1", s_arready);
        else pass_cnt++;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 32'hA500_0000 | 32'(i);
        test_reset();
        test_incr();
        test_wrap();
        test_fixed();
        test_backpressure();
        test_slverr();
        test_decerr();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/axi4_read_responder.md
# axi4_read_responder

AXI4 read-channel subordinate that sits between the memory-side AXI4 port and a single-port word-addressed backing RAM. It completes the bus opposite the cache's read initiator. It accepts one AR burst at a time and generates per-beat addresses for FIXED, INCR and WRAP bursts. It fetches each beat from the RAM and returns it on the R channel with correct RID, RRESP and RLAST, honouring RREADY backpressure. Illegal bursts and out-of-range addresses are answered with error responses, never dropped.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, R data width; bytes per word = DATA_WIDTH/8
- ID_WIDTH, 4, transaction ID width
- MEM_WORDS, 1024, backing RAM depth in words; MEM_AW = $clog2(MEM_WORDS)

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- s_arid  in  ID_WIDTH  read ID
- s_araddr  in  ADDR_WIDTH  burst start byte address
- s_arlen  in  8  beats minus one
- s_arsize  in  3  log2 bytes per beat
- s_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- s_arvalid  in  1  AR valid
- s_arready  out  1  AR ready (registered)
- s_rid  out  ID_WIDTH  echoed ARID
- s_rdata  out  DATA_WIDTH  read data
- s_rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
- s_rlast  out  1  final beat
- s_rvalid  out  1  R valid
- s_rready  in  1  R ready
- mem_req  out  1  RAM read strobe
- mem_addr  out  MEM_AW  RAM word address
- mem_rdata  in  DATA_WIDTH  valid the cycle after mem_req; RAM holds it until the next mem_req

## Operation
- States: IDLE, FETCH, DATA.
- IDLE: s_arready=1. On s_arvalid & s_arready, latch id, addr, len, size and burst, clear beat counter, then:
  - go to DATA with err=SLVERR if the burst is illegal, i.e. s_arsize > log2(DATA_WIDTH/8), or burst==11, or WRAP with len not in {1,3,7,15};
  - otherwise go to FETCH.
- FETCH: compute the current beat address.
  - If it is ≥ MEM_WORDS*DATA_WIDTH/8, the beat is DECERR with no mem_req.
  - Otherwise mem_req=1 and mem_addr = addr >> log2(DATA_WIDTH/8).
  - Next state is always DATA.
- DATA: s_rvalid=1.
  - s_rdata = mem_rdata for OKAY beats, 0 for error beats.
  - s_rresp: OKAY, SLVERR or DECERR as determined for the beat.
  - s_rlast = (beat==len).
  - s_rid = latched id.
  - All R outputs stay stable while s_rready=0.
  - On s_rready with the last beat: go to IDLE.
  - On s_rready otherwise: increment beat and advance the address. The next state is FETCH, or DATA directly for SLVERR bursts, which return one beat per cycle.
- Address sequencing, with bytes = 1<<size:
  - FIXED: every beat uses the start address.
  - INCR: beat0 = start. Beat n = (start & ~(bytes-1)) + n*bytes, computed modulo 2^ADDR_WIDTH. 4 KB crossing is not checked.
  - WRAP: total = bytes*(len+1), lower = start & ~(total-1). The next address is addr+bytes; if that equals lower+total, it becomes lower.
- Narrow beats return the full RAM word; the initiator selects lanes.
- DECERR is evaluated per beat, so an INCR burst can mix OKAY and DECERR beats.

## Timing
- While rst_n=0: s_arready=0, s_rvalid=0, s_rlast=0, s_rid=0, s_rresp=0, s_rdata=0, mem_req=0, mem_addr=0, state=IDLE.
- s_arready becomes 1 at the first rising edge after reset release.
- AR handshake at edge 0:
  - s_arready=0 from cycle 1;
  - FETCH in cycle 1;
  - first s_rvalid in cycle 2.
- With s_rready held at 1, legal bursts deliver one beat every 2 cycles. SLVERR bursts deliver one beat per cycle starting in cycle 1.
- After the last-beat handshake at edge k, s_arready=1 in cycle k+1. There is no overlap of bursts, and the responder has no outstanding-transaction queue.
- s_rvalid never deasserts before its handshake.
- mem_req is asserted only in FETCH, for exactly one cycle per non-error beat.
- If rst_n is asserted mid-burst, the burst is abandoned and outputs take their reset values immediately (asynchronously). No partial R beats are completed.

## Test plan
- INCR, araddr=0x10, len=3, size=2, rready=1: mem_addr 4,5,6,7; rvalid in cycles 2,4,6,8; rlast only on the 4th beat; rresp=00; rid equals arid.
- WRAP, araddr=0x38, len=3, size=2: mem_addr 0xE,0xF,0xC,0xD; rlast on beat 3; arready returns 1 the cycle after.
- FIXED, araddr=0x20, len=2: mem_addr 8,8,8; three beats.
- Backpressure: INCR len=1 with rready=0 for 3 cycles on beat 0: rdata, rid, rresp and rlast are stable; no second mem_req until after the handshake.
- Errors:
  - WRAP with len=2: 3 SLVERR beats on consecutive cycles, rdata=0, mem_req never asserted.
  - INCR at araddr=0xFFC, len=1, MEM_WORDS=1024: beat0 OKAY at word 0x3FF, beat1 DECERR at 0x1000 with no mem_req.
- Reset mid-burst: assert rst_n=0 during beat 2 of a len=7 INCR: rvalid=0 immediately. After release, arready=1 at the first edge and a new burst completes normally.
